// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates a group of signed partial sums from the PE.
// At the end of the group the sum is requantized with a rounding arithmetic
// right shift, then saturated to an OW-bit activation. The result is held in
// a single registered valid/ready output slot.
// Optional build macro PSUM_ACC_RELU_EN: negative results are forced to zero
// before output saturation, so o_sat then reports only positive clipping.
module psum_accumulator #(
    parameter int IW = 17,
    parameter int AW = 24,
    parameter int OW = 8,
    parameter int SW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [IW-1:0] i_psum,
    input  logic          i_last,
    input  logic [SW-1:0] i_shift,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_ovf,
    output logic          o_sat
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [AW:0]   ACC_MAX = (AW+1)'((1 << (AW-1)) - 1);
    localparam logic signed [AW:0]   ACC_MIN = (AW+1)'(-(1 << (AW-1)));
    localparam logic signed [AW+1:0] Q_MAX   = (AW+2)'((1 << (OW-1)) - 1);
    localparam logic signed [AW+1:0] Q_MIN   = (AW+2)'(-(1 << (OW-1)));

    state_t                 state_q, state_d;
    logic   [AW-1:0]        acc_q;
    logic                   ovf_q;
    logic                   accept;

    logic signed [AW:0]     sum_raw;
    logic signed [AW-1:0]   sum_c;
    logic                   clamp;
    logic                   ovf_d;
    logic [SW-1:0]          sh_e;
    logic signed [AW+1:0]   rnd, biased, r;
    logic signed [OW-1:0]   q_d;
    logic                   sat_d;

    assign accept = i_valid && (state_q != OUT);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and ready; flush wins over everything, including a handshake
    always_comb begin
        state_d = state_q;
        o_ready = (state_q != OUT);
        if (i_flush)                        state_d = IDLE;
        else if (accept)                    state_d = i_last ? OUT : ACC;
        else if (state_q == OUT && i_ready) state_d = IDLE;
    end

    // Accumulate with clamp, then round/shift/saturate for the closing beat
    always_comb begin
        // A beat taken in IDLE starts a fresh group, so the old acc is ignored
        sum_raw = (state_q == IDLE ? '0 : {acc_q[AW-1], acc_q})
                + {{(AW+1-IW){i_psum[IW-1]}}, i_psum};
        clamp = 1'b0;
        sum_c = sum_raw[AW-1:0];
        if (sum_raw > ACC_MAX) begin
            sum_c = AW'(ACC_MAX);
            clamp = 1'b1;
        end else if (sum_raw < ACC_MIN) begin
            sum_c = AW'(ACC_MIN);
            clamp = 1'b1;
        end
        ovf_d = ((state_q == IDLE) ? 1'b0 : ovf_q) | clamp;

        // Any shift beyond AW+1 gives the same rounded result (0) as AW+1,
        // so the shift is capped there and the rounding term fits AW+2 bits.
        sh_e   = (32'(i_shift) > AW + 1) ? SW'(AW + 1) : i_shift;
        rnd    = '0;
        if (sh_e != '0) rnd = (AW+2)'(1) << (sh_e - 1'b1);
        biased = {{2{sum_c[AW-1]}}, sum_c} + rnd;
        r      = biased >>> sh_e;
`ifdef PSUM_ACC_RELU_EN
        if (r[AW+1]) r = '0;
`endif
        sat_d = 1'b0;
        q_d   = OW'(r);
        if (r > Q_MAX) begin
            q_d   = OW'(Q_MAX);
            sat_d = 1'b1;
        end else if (r < Q_MIN) begin
            q_d   = OW'(Q_MIN);
            sat_d = 1'b1;
        end
    end

    // Accumulator, sticky overflow and the registered output slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ovf   <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_flush) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            o_valid <= 1'b0;
        end else if (accept) begin
            ovf_q <= ovf_d;
            if (i_last) begin
                acc_q   <= '0;
                o_valid <= 1'b1;
                o_data  <= q_d;
                o_sat   <= sat_d;
                o_ovf   <= ovf_d;
            end else begin
                acc_q <= sum_c;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            acc_q   <= '0;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the accumulator group semantics.
module tb_psum_accumulator;

    localparam int IW = 17, AW = 24, OW = 8, SW = 5;
    localparam longint ACC_MAX = (longint'(1) << (AW-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (AW-1));
    localparam longint Q_MAX   = (longint'(1) << (OW-1)) - 1;
    localparam longint Q_MIN   = -(longint'(1) << (OW-1));

    logic          i_clk = 1'b0, i_rst_n = 1'b0;
    logic          i_valid = 1'b0, i_last = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
    logic [IW-1:0] i_psum = '0;
    logic [SW-1:0] i_shift = '0;
    logic          o_ready, o_valid, o_ovf, o_sat;
    logic [OW-1:0] o_data;

    psum_accumulator #(.IW(IW), .AW(AW), .OW(OW), .SW(SW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_psum(i_psum), .i_last(i_last), .i_shift(i_shift), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ovf(o_ovf),
        .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;

    // Model: open group sum, sticky overflow, pending result
    bit     m_open, m_pend, m_ovf, mr_ovf, mr_sat;
    longint m_acc, mr_data;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_open = 0; m_pend = 0; m_ovf = 0; m_acc = 0;
    endtask

    task automatic m_edge(input bit v, input longint p, input bit l, input int sh,
                          input bit f, input bit r);
        longint s, q;
        bit     ov;
        if (f) begin
            m_reset();
        end else if (v && !m_pend) begin
            s  = (m_open ? m_acc : 0) + p;
            ov = m_open ? m_ovf : 1'b0;
            if (s > ACC_MAX) begin s = ACC_MAX; ov = 1; end
            else if (s < ACC_MIN) begin s = ACC_MIN; ov = 1; end
            if (l) begin
                q = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
`ifdef PSUM_ACC_RELU_EN
                if (q < 0) q = 0;
`endif
                mr_sat = 0;
                if (q > Q_MAX) begin q = Q_MAX; mr_sat = 1; end
                else if (q < Q_MIN) begin q = Q_MIN; mr_sat = 1; end
                mr_data = q; mr_ovf = ov;
                m_pend = 1; m_open = 0; m_acc = 0; m_ovf = 0;
            end else begin
                m_acc = s; m_ovf = ov; m_open = 1;
            end
        end else if (m_pend && r) begin
            m_pend = 0;
        end
    endtask

    // One clock: drive, check ready, clock, update model, check outputs
    task automatic step(input bit v, input int p, input bit l, input int sh,
                        input bit f, input bit r);
        i_valid = v; i_psum = IW'(p); i_last = l; i_shift = SW'(sh);
        i_flush = f; i_ready = r;
        chk("o_ready", longint'(o_ready), longint'(!m_pend));
        @(posedge i_clk);
        m_edge(v, p, l, sh, f, r);
        #1;
        chk("o_valid", longint'(o_valid), longint'(m_pend));
        if (m_pend) begin
            chk("o_data", longint'($signed(o_data)), mr_data);
            chk("o_sat", longint'(o_sat), longint'(mr_sat));
            chk("o_ovf", longint'(o_ovf), longint'(mr_ovf));
        end
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any edge
    task automatic async_reset(input string tag);
        #2 i_rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, longint'(o_valid), 0);
        chk({tag, "_data"}, longint'(o_data), 0);
        chk({tag, "_ovf"}, longint'(o_ovf), 0);
        chk({tag, "_sat"}, longint'(o_sat), 0);
        m_reset();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        bit v, l, f, r;
        int p, sh, sgn;

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_data", longint'(o_data), 0);
        chk("rst_ovf", longint'(o_ovf), 0);
        chk("rst_sat", longint'(o_sat), 0);
        i_rst_n = 1'b1;
        m_reset();

        // Basic group
        step(1, 5100, 0, 0, 0, 1);
        step(1, 150, 0, 0, 0, 1);
        step(1, 401, 1, 6, 0, 1);
        chk("basic_data", longint'($signed(o_data)), 88);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Positive saturation, single-beat group
        step(1, 5100, 1, 0, 0, 1);
        chk("sat_data", longint'($signed(o_data)), 127);
        chk("sat_flag", longint'(o_sat), 1);
        step(0, 0, 0, 0, 0, 1);

        // Negative result
        step(1, -300, 0, 0, 0, 1);
        step(1, -50, 1, 2, 0, 1);
`ifdef PSUM_ACC_RELU_EN
        chk("neg_data", longint'($signed(o_data)), 0);
`else
        chk("neg_data", longint'($signed(o_data)), -87);
`endif
        step(0, 0, 0, 0, 0, 1);

        // Backpressure: extra beats must be refused while the result waits
        step(1, 10, 0, 0, 0, 0);
        step(1, 20, 1, 0, 0, 0);
        repeat (3) step(1, 999, 0, 0, 0, 0);
        chk("bp_data", longint'($signed(o_data)), 30);
        step(0, 0, 0, 0, 0, 1);
        step(1, 64, 1, 3, 0, 1);
        chk("bp_next", longint'($signed(o_data)), 8);
        step(0, 0, 0, 0, 0, 1);

        // Flush mid-group with a concurrent beat, then flush in OUT
        step(1, 1000, 0, 0, 0, 1);
        step(1, 2000, 0, 0, 0, 1);
        step(1, 7, 0, 0, 1, 1);
        step(1, 64, 1, 3, 0, 1);
        chk("flush_next", longint'($signed(o_data)), 8);
        step(0, 0, 0, 0, 1, 1);
        chk("flush_out", longint'(o_valid), 0);
        step(0, 0, 0, 0, 0, 1);

        // Accumulator overflow
        repeat (128) step(1, 65535, 0, 0, 0, 1);
        step(1, 65535, 1, 16, 0, 1);
        chk("ovf_data", longint'($signed(o_data)), 127);
        chk("ovf_flag", longint'(o_ovf), 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0, 1);
        chk("ovf_clear", longint'(o_ovf), 0);
        step(0, 0, 0, 0, 0, 1);

        // Async reset in OUT and mid-group
        step(1, 100, 0, 0, 0, 0);
        step(1, 100, 1, 0, 0, 0);
        async_reset("rst_out");
        step(1, 300, 0, 0, 0, 1);
        async_reset("rst_grp");
        step(1, 64, 1, 3, 0, 1);
        chk("rst_next", longint'($signed(o_data)), 8);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic: short groups, then long groups to reach clamps
        sgn = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                v  = ($urandom_range(0, 3) != 0);
                p  = int'($urandom_range(0, 131071)) - 65536;
                l  = ($urandom_range(0, 3) == 0);
                f  = ($urandom_range(0, 39) == 0);
                r  = ($urandom_range(0, 1) == 1);
            end else begin
                if (i % 500 == 0) sgn = -sgn;
                v  = ($urandom_range(0, 7) != 0);
                p  = sgn * int'($urandom_range(40000, 65535));
                l  = ($urandom_range(0, 199) == 0);
                f  = ($urandom_range(0, 399) == 0);
                r  = ($urandom_range(0, 3) != 0);
            end
            sh = int'($urandom_range(0, 31));
            step(v, p, l, sh, f, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
